// File: rtl/mem_req_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and mem_cntrl.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_req_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_r_en;
  logic [DATA_WIDTH-1:0] f_data;
  logic                  f_cplt;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_r_en;
  logic                  d_w_en;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_cplt;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [DATA_WIDTH-1:0] mem_data_out;

  logic                  busy;

  modport slave (
    input  f_addr, f_r_en, d_addr, d_wdata, d_r_en, d_w_en,
    input  mem_rdy, mem_cplt, mem_data_out,
    output f_data, f_cplt, d_rdata, d_cplt,
    output mem_addr, mem_data_in, mem_r_en, mem_w_en, busy
  );

  modport master (
    output f_addr, f_r_en, d_addr, d_wdata, d_r_en, d_w_en,
    output mem_rdy, mem_cplt, mem_data_out,
    input  f_data, f_cplt, d_rdata, d_cplt,
    input  mem_addr, mem_data_in, mem_r_en, mem_w_en, busy
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging instruction fetch (port 0) and CPU data (port 1)
// onto mem_cntrl, with one outstanding transaction and registered outputs.
module mem_req_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state, state_nxt;
  logic                  grant, grant_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  op_wr, op_wr_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_nxt;
  logic                  mem_r_en_q, mem_r_en_nxt;
  logic                  mem_w_en_q, mem_w_en_nxt;
  logic [DATA_WIDTH-1:0] f_data_q, f_data_nxt;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_nxt;
  logic                  f_cplt_q, f_cplt_nxt;
  logic                  d_cplt_q, d_cplt_nxt;
  logic                  busy_q, busy_nxt;
  logic                  f_req, d_req, sel;

  assign f_req = bus.f_r_en;
  assign d_req = bus.d_r_en | bus.d_w_en;

  // Next-state and next-output logic; grant/sel: 0 = fetch, 1 = data.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    last_grant_nxt  = last_grant;
    op_wr_nxt       = op_wr;
    mem_addr_nxt    = mem_addr_q;
    mem_data_in_nxt = mem_data_in_q;
    mem_r_en_nxt    = mem_r_en_q;
    mem_w_en_nxt    = mem_w_en_q;
    f_data_nxt      = f_data_q;
    d_rdata_nxt     = d_rdata_q;
    f_cplt_nxt      = 1'b0;
    d_cplt_nxt      = 1'b0;
    busy_nxt        = busy_q;
    sel             = 1'b0;

    case (state)
      IDLE: begin
        if (f_req | d_req) begin
          sel       = (f_req & d_req) ? ~last_grant : d_req;
          grant_nxt = sel;
          if (sel) begin
            mem_addr_nxt    = bus.d_addr;
            mem_data_in_nxt = bus.d_wdata;
            op_wr_nxt       = bus.d_w_en;
          end else begin
            mem_addr_nxt    = bus.f_addr;
            op_wr_nxt       = 1'b0;
          end
          mem_r_en_nxt = ~op_wr_nxt;
          mem_w_en_nxt = op_wr_nxt;
          busy_nxt     = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_rdy) begin
          mem_r_en_nxt = 1'b0;
          mem_w_en_nxt = 1'b0;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_cplt) begin
          // Write completions leave the read-data registers untouched.
          if (grant) begin
            d_cplt_nxt = 1'b1;
            if (!op_wr) d_rdata_nxt = bus.mem_data_out;
          end else begin
            f_cplt_nxt = 1'b1;
            f_data_nxt = bus.mem_data_out;
          end
          last_grant_nxt = grant;
          busy_nxt       = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      op_wr         <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_r_en_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
      f_data_q      <= '0;
      d_rdata_q     <= '0;
      f_cplt_q      <= 1'b0;
      d_cplt_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      last_grant    <= last_grant_nxt;
      op_wr         <= op_wr_nxt;
      mem_addr_q    <= mem_addr_nxt;
      mem_data_in_q <= mem_data_in_nxt;
      mem_r_en_q    <= mem_r_en_nxt;
      mem_w_en_q    <= mem_w_en_nxt;
      f_data_q      <= f_data_nxt;
      d_rdata_q     <= d_rdata_nxt;
      f_cplt_q      <= f_cplt_nxt;
      d_cplt_q      <= d_cplt_nxt;
      busy_q        <= busy_nxt;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_r_en    = mem_r_en_q;
  assign bus.mem_w_en    = mem_w_en_q;
  assign bus.f_data      = f_data_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.f_cplt      = f_cplt_q;
  assign bus.d_cplt      = d_cplt_q;
  assign bus.busy        = busy_q;

endmodule
